// File: rtl/sized_literal_emitter_pkg.sv
// Shared types and ASCII constants for the sized-literal emitter.
package lit_pkg;

    typedef enum logic [1:0] {LIT_BIN, LIT_OCT, LIT_HEX, LIT_RSVD} lit_base_e;

    typedef enum logic [2:0] {IDLE, WID_TENS, WID_ONES, TICK, BASE, DIGITS} emit_state_e;

    localparam logic [7:0] CH_TICK = 8'h27;
    localparam logic [7:0] CH_b    = 8'h62;
    localparam logic [7:0] CH_o    = 8'h6f;
    localparam logic [7:0] CH_h    = 8'h68;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_a    = 8'h61;

    function automatic logic [7:0] base_char(input lit_base_e b);
        case (b)
            LIT_BIN: base_char = CH_b;
            LIT_OCT: base_char = CH_o;
            default: base_char = CH_h;
        endcase
    endfunction

endpackage

// File: rtl/sized_literal_emitter_digit.sv
// Combinational 4-bit digit to lowercase ASCII hex character.
module lit_digit_ascii
    import lit_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    always_comb begin
        if (digit < 4'd10) ascii = CH_0 + {4'b0000, digit};
        else               ascii = CH_a + {4'b0000, digit} - 8'd10;
    end

endmodule

// File: rtl/sized_literal_emitter.sv
// Emits a (value, width, base) request as a Verilog sized literal,
// one ASCII byte per cycle on a valid/ready stream.
module sized_literal_emitter
    import lit_pkg::*;
#(
    parameter int unsigned MAX_W = 64,
    parameter int unsigned WW    = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [MAX_W-1:0] req_value,
    input  logic [WW-1:0]    req_width,
    input  logic [1:0]       req_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             err,
    output logic             busy
);

    localparam int unsigned IW = $clog2(MAX_W) + 1;

    emit_state_e      state;
    logic [MAX_W+2:0] val;   // padded so a 4-bit digit slice always exists
    logic [3:0]       tens;
    logic [3:0]       ones;
    lit_base_e        base;
    logic [IW-1:0]    idx;

    // Accept-time decode
    logic [7:0]       w8;
    logic             acc_err;
    logic [3:0]       tens_c;
    logic [3:0]       ones_c;
    logic [7:0]       ten_x;
    logic [7:0]       ndig_c;
    logic [MAX_W-1:0] vmask;

    always_comb begin
        w8      = 8'(req_width);
        acc_err = (w8 == 8'd0) || (w8 > 8'(MAX_W)) || (req_base == 2'd3);
        tens_c  = '0;
        for (int unsigned t = 1; t <= 9; t++) begin
            if (w8 >= 8'(t * 10)) tens_c = 4'(t);
        end
        ten_x  = ({4'b0000, tens_c} << 3) + ({4'b0000, tens_c} << 1);
        ones_c = 4'(w8 - ten_x);
        for (int unsigned i = 0; i < MAX_W; i++) begin
            vmask[i] = (i < 32'(w8));
        end
        case (lit_base_e'(req_base))
            LIT_BIN: ndig_c = w8;
            LIT_OCT: ndig_c = (w8 + 8'd2) / 8'd3;
            default: ndig_c = (w8 + 8'd3) >> 2;
        endcase
    end

    // Digit for the character about to be loaded into out_char
    logic [IW-1:0] dig_idx;
    logic [IW+1:0] shamt;
    logic [3:0]    dmask;
    logic [3:0]    nib;
    logic [7:0]    dig_ascii;

    always_comb begin
        dig_idx = (state == DIGITS) ? idx - IW'(1) : idx;
        case (base)
            LIT_BIN: begin
                shamt = {2'b00, dig_idx};
                dmask = 4'h1;
            end
            LIT_OCT: begin
                shamt = {1'b0, dig_idx, 1'b0} + {2'b00, dig_idx};
                dmask = 4'h7;
            end
            default: begin
                shamt = {dig_idx, 2'b00};
                dmask = 4'hf;
            end
        endcase
        nib = 4'(val >> shamt) & dmask;
    end

    lit_digit_ascii u_digit (
        .digit (nib),
        .ascii (dig_ascii)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            val       <= '0;
            tens      <= '0;
            ones      <= '0;
            base      <= LIT_BIN;
            idx       <= '0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (req_valid) begin
                    if (acc_err) begin
                        err <= 1'b1;
                    end else begin
                        val       <= {3'b000, req_value & vmask};
                        tens      <= tens_c;
                        ones      <= ones_c;
                        base      <= lit_base_e'(req_base);
                        idx       <= IW'(ndig_c - 8'd1);
                        req_ready <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= 1'b0;
                        if (tens_c != 4'd0) begin
                            state    <= WID_TENS;
                            out_char <= CH_0 + {4'b0000, tens_c};
                        end else begin
                            state    <= WID_ONES;
                            out_char <= CH_0 + {4'b0000, ones_c};
                        end
                    end
                end
            end else if (out_valid && out_ready) begin
                case (state)
                    WID_TENS: begin
                        state    <= WID_ONES;
                        out_char <= CH_0 + {4'b0000, ones};
                    end
                    WID_ONES: begin
                        state    <= TICK;
                        out_char <= CH_TICK;
                    end
                    TICK: begin
                        state    <= BASE;
                        out_char <= base_char(base);
                    end
                    BASE: begin
                        state    <= DIGITS;
                        out_char <= dig_ascii;
                        out_last <= (idx == '0);
                    end
                    default: begin
                        if (idx == '0) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            idx      <= idx - IW'(1);
                            out_char <= dig_ascii;
                            out_last <= (idx == IW'(1));
                        end
                    end
                endcase
            end
        end
    end

endmodule
